alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 16-bit combinational ALU. Operands are accepted over a valid/ready input channel and results are returned with registered flags over a valid/ready output channel. Multiply and divide are iterative and multi-cycle; divide is a true quotient/remainder divide with divide-by-zero detection. The block sits between register-file read and write-back, and the control unit stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 16: operand and result width in bits; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH+1): width of the iteration counter; derived, do not override.
---
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: operands and op are valid.
- `in_ready` output 1: block can accept an operation this cycle.
- `d_in_1` input WIDTH: operand A.
- `d_in_2` input WIDTH: operand B.
- `alu_op` input 3: operation code, see Operation.
- `out_valid` output 1: result and flags are valid.
- `out_ready` input 1: consumer accepts the result.
- `d_out` output WIDTH: primary result.
- `d_out_hi` output WIDTH: MUL upper half, or DIV remainder; 0 for other ops.
- `z_flag` output 1: `d_out == 0`.
- `a_grt_b` output 1: `d_in_1 > d_in_2`, unsigned.
- `b_grt_a` output 1: `d_in_1 < d_in_2`, unsigned.
- `c_flag` output 1: ADD carry-out, or SUB borrow; 0 otherwise.
- `dz_flag` output 1: DIV with `d_in_2 == 0`.

## Operation
- Op codes:
  - 000 ADD: `d_out = A+B`, carry to `c_flag`.
  - 001 MUL: full 2·WIDTH product, low half to `d_out`, high half to `d_out_hi`.
  - 010 AND.
  - 011 OR.
  - 100 DIV: `d_out = A/B`, `d_out_hi = A%B`.
  - 101 GT: `d_out = {0…, A>B}`.
  - 110 LT: `d_out = {0…, A<B}`.
  - 111 SUB: `d_out = A-B` mod 2^WIDTH, `c_flag = A<B`.
- All arithmetic is unsigned.
- `a_grt_b` and `b_grt_a` are computed from the captured operands for every op. `z_flag` always reflects `d_out`.
- FSM states IDLE, BUSY, DONE:
  - IDLE → DONE on accept of a single-cycle op (everything except MUL and DIV with B≠0). The result is registered on the accept edge.
  - IDLE → BUSY on accept of MUL, or of DIV with B≠0. Operands are captured and the counter is loaded with WIDTH.
  - BUSY: one iteration per cycle (shift-add for MUL, restoring shift-subtract for DIV). The counter decrements each cycle; BUSY → DONE on the edge where the counter reaches 0.
  - DONE: outputs held stable while `out_valid`=1 and `out_ready`=0. On an output handshake the next state is IDLE, or directly DONE/BUSY if a new op is accepted on the same edge.
- DIV by zero is a single-cycle op: `d_out` = all ones, `d_out_hi = A`, `dz_flag` = 1, `z_flag` = 0.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). This is combinational from `out_ready`, and it is the only such path.
- Operands, op and flags are captured internally, so inputs may change after acceptance without affecting the result.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = IDLE.
  - `out_valid` = 0.
  - `d_out` = 0 and `d_out_hi` = 0.
  - All flags = 0.
  - `in_ready` = 1 once out of reset.
- Reset asserted mid-BUSY or in DONE aborts the operation with no output.
- Single-cycle op accepted at edge N: `out_valid`=1 after edge N.
- MUL or DIV accepted at edge N: `out_valid`=1 after edge N+WIDTH (WIDTH BUSY cycles).
- With `out_ready` held high, single-cycle ops sustain one result per cycle. Back-to-back MUL/DIV sustain one per WIDTH+1 cycles.
- `out_valid` never drops without an output handshake.

## Structure
- Package `alu_pkg`:
  - Op-code localparams (`OP_ADD`…`OP_SUB`).
  - FSM state typedef (IDLE/BUSY/DONE).
  - `is_multicycle(op, b)` function.
- Sub-module `alu_iter_muldiv`, parameterised by WIDTH:
  - Holds the accumulator/remainder and shift registers and the counter.
  - Interface: `start`, `is_div`, A, B → `done`, `lo`, `hi`.
- The top level holds the FSM, the single-cycle datapath, and the output/flag registers.

## Test plan
- Reset: assert `rst_n`=0 mid-BUSY of a MUL → `out_valid`=0, all outputs 0 immediately. After release, `in_ready`=1.
- ADD, WIDTH=16: `0xFFFF + 0x0001` with `out_ready`=1 → next cycle `d_out`=0x0000, `c_flag`=1, `z_flag`=1, `a_grt_b`=1.
- MUL: `0x1234 × 0x5678` → `out_valid` exactly 16 cycles after accept, `d_out`=0x0060, `d_out_hi`=0x0626, `in_ready`=0 throughout BUSY.
- DIV: `100 / 7` → `d_out`=14, `d_out_hi`=2. Then `0x00AB / 0` → 1 cycle later `d_out`=0xFFFF, `d_out_hi`=0x00AB, `dz_flag`=1.
- Backpressure: SUB `5 − 9` with `out_ready`=0 for 5 cycles → `d_out`=0xFFFC, `c_flag`=1, `b_grt_a`=1. Outputs are stable and `in_ready`=0 until `out_ready` rises; a new op is accepted on that same edge.
- Throughput and parameters: 8 back-to-back AND/OR/GT/LT ops at `out_ready`=1 → 8 results in 8 consecutive cycles, matching a reference model. Repeat randomised MUL/DIV checks at WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the handshaked sequential ALU:
//   - op-code constants OP_ADD .. OP_SUB
//   - FSM state type (IDLE / BUSY / DONE)
//   - is_multicycle(): tells whether an op needs the iterative unit
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_SUB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // DIV by zero is resolved in a single cycle, so only a non-zero divisor
    // sends a DIV to the iterative unit.
    function automatic logic is_multicycle(input logic [2:0] op, input logic b_nonzero);
        return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// ---------------------------------------------------------------------------
// alu_iter_muldiv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           load operands and begin WIDTH iterations
//   is_div          1 = divide, 0 = multiply (sampled on start)
//   a, b            operands (sampled on start)
//   done            high during the cycle of the last iteration
//   lo, hi          result of the current iteration (valid when done):
//                   MUL -> low/high product, DIV -> quotient/remainder
// ---------------------------------------------------------------------------
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    // hi_q: MUL partial product high half / DIV partial remainder
    // lo_q: MUL multiplier shifting out low bits / DIV dividend shifting
    //       out while quotient bits shift in
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi, div_lo;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        // Shift-add: conditionally add B into the high half, then shift the
        // whole {carry, hi, lo} right by one.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

        // Restoring divide: bring in the next dividend bit; bit WIDTH of the
        // difference is the borrow since the partial remainder stays < B.
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[WIDTH];
        div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo    = {lo_q[WIDTH-2:0], div_ge};

        step_hi = is_div_q ? div_hi : mul_hi;
        step_lo = is_div_q ? div_lo : mul_lo;
    end

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        if (start) begin
            hi_d     = '0;
            lo_d     = a;
            b_d      = b;
            cnt_d    = CNT_W'(WIDTH);
            is_div_d = is_div;
        end else if (cnt_q != '0) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
        end
    end

    // The final iteration's result is presented combinationally so the
    // parent can register it on the same edge the counter reaches zero.
    assign done = (cnt_q == CNT_W'(1));
    assign lo   = step_lo;
    assign hi   = step_hi;

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked unsigned ALU with registered result and flags.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand channel (d_in_1 = A, d_in_2 = B, alu_op)
//   out_valid / out_ready result channel
//   d_out, d_out_hi       result; d_out_hi = MUL high half or DIV remainder
//   z_flag                d_out == 0
//   a_grt_b, b_grt_a      unsigned A > B, A < B of the accepted operands
//   c_flag                ADD carry / SUB borrow
//   dz_flag               DIV with B == 0
// MUL and DIV (B != 0) take WIDTH BUSY cycles; all other ops complete on
// the accept edge.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in_1,
    input  logic [WIDTH-1:0] d_in_2,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] d_out_hi,
    output logic             z_flag,
    output logic             a_grt_b,
    output logic             b_grt_a,
    output logic             c_flag,
    output logic             dz_flag
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic [WIDTH-1:0] d_out_hi_q, d_out_hi_d;
    logic             z_q, z_d;
    logic             agb_q, agb_d;
    logic             bga_q, bga_d;
    logic             c_q, c_d;
    logic             dz_q, dz_d;
    // Compare flags of an op in flight through the iterative unit
    logic             pend_agb_q, pend_agb_d;
    logic             pend_bga_q, pend_bga_d;

    logic             accept;
    logic             multi;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    logic [WIDTH:0]   sum;
    logic             a_gt, a_lt;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_c, sc_dz;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign multi     = is_multicycle(alu_op, |d_in_2);
    assign md_start  = accept && multi;

    // Single-cycle datapath
    always_comb begin
        sum   = {1'b0, d_in_1} + {1'b0, d_in_2};
        a_gt  = (d_in_1 > d_in_2);
        a_lt  = (d_in_1 < d_in_2);
        sc_lo = '0;
        sc_hi = '0;
        sc_c  = 1'b0;
        sc_dz = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sc_lo = sum[WIDTH-1:0];
                sc_c  = sum[WIDTH];
            end
            OP_AND: sc_lo = d_in_1 & d_in_2;
            OP_OR:  sc_lo = d_in_1 | d_in_2;
            OP_GT:  sc_lo = {{(WIDTH-1){1'b0}}, a_gt};
            OP_LT:  sc_lo = {{(WIDTH-1){1'b0}}, a_lt};
            OP_SUB: begin
                sc_lo = d_in_1 - d_in_2;
                sc_c  = a_lt;
            end
            OP_DIV: begin
                // Only reaches here with B == 0
                sc_lo = '1;
                sc_hi = d_in_1;
                sc_dz = 1'b1;
            end
            default: ;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (alu_op == OP_DIV),
        .a      (d_in_1),
        .b      (d_in_2),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = multi ? BUSY : DONE;
            BUSY: if (md_done) state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    if (in_valid) state_d = multi ? BUSY : DONE;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result / flag register next values
    always_comb begin
        d_out_d    = d_out_q;
        d_out_hi_d = d_out_hi_q;
        z_d        = z_q;
        agb_d      = agb_q;
        bga_d      = bga_q;
        c_d        = c_q;
        dz_d       = dz_q;
        pend_agb_d = pend_agb_q;
        pend_bga_d = pend_bga_q;
        if (accept && !multi) begin
            d_out_d    = sc_lo;
            d_out_hi_d = sc_hi;
            z_d        = (sc_lo == '0);
            agb_d      = a_gt;
            bga_d      = a_lt;
            c_d        = sc_c;
            dz_d       = sc_dz;
        end else if (md_start) begin
            pend_agb_d = a_gt;
            pend_bga_d = a_lt;
        end else if ((state_q == BUSY) && md_done) begin
            d_out_d    = md_lo;
            d_out_hi_d = md_hi;
            z_d        = (md_lo == '0);
            agb_d      = pend_agb_q;
            bga_d      = pend_bga_q;
            c_d        = 1'b0;
            dz_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            d_out_q    <= '0;
            d_out_hi_q <= '0;
            z_q        <= 1'b0;
            agb_q      <= 1'b0;
            bga_q      <= 1'b0;
            c_q        <= 1'b0;
            dz_q       <= 1'b0;
            pend_agb_q <= 1'b0;
            pend_bga_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_out_q    <= d_out_d;
            d_out_hi_q <= d_out_hi_d;
            z_q        <= z_d;
            agb_q      <= agb_d;
            bga_q      <= bga_d;
            c_q        <= c_d;
            dz_q       <= dz_d;
            pend_agb_q <= pend_agb_d;
            pend_bga_q <= pend_bga_d;
        end
    end

    assign d_out    = d_out_q;
    assign d_out_hi = d_out_hi_q;
    assign z_flag   = z_q;
    assign a_grt_b  = agb_q;
    assign b_grt_a  = bga_q;
    assign c_flag   = c_q;
    assign dz_flag  = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH = 16 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a16, b16, d_out, d_out_hi;
    logic [2:0]  op16;
    logic        z_flag, a_grt_b, b_grt_a, c_flag, dz_flag;

    // WIDTH = 8 and WIDTH = 32 instances share the operand bus
    logic [31:0] a_w, b_w;
    logic [2:0]  op_w;
    logic        or_w;
    logic        iv8, ir8, ov8, z8, agb8, bga8, c8, dz8;
    logic [7:0]  lo8, hi8;
    logic        iv32, ir32, ov32, z32, agb32, bga32, c32, dz32;
    logic [31:0] lo32, hi32;

    int n_assert = 0;
    int n_fail   = 0;
    logic busy_ready;

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .d_in_1(a16), .d_in_2(b16), .alu_op(op16), .out_valid(out_valid),
        .out_ready(out_ready), .d_out(d_out), .d_out_hi(d_out_hi), .z_flag(z_flag),
        .a_grt_b(a_grt_b), .b_grt_a(b_grt_a), .c_flag(c_flag), .dz_flag(dz_flag)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .d_in_1(a_w[7:0]), .d_in_2(b_w[7:0]), .alu_op(op_w), .out_valid(ov8),
        .out_ready(or_w), .d_out(lo8), .d_out_hi(hi8), .z_flag(z8),
        .a_grt_b(agb8), .b_grt_a(bga8), .c_flag(c8), .dz_flag(dz8)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .d_in_1(a_w), .d_in_2(b_w), .alu_op(op_w), .out_valid(ov32),
        .out_ready(or_w), .d_out(lo32), .d_out_hi(hi32), .z_flag(z32),
        .a_grt_b(agb32), .b_grt_a(bga32), .c_flag(c32), .dz_flag(dz32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    // Issue one op on the 16-bit DUT (called just after a negedge) and wait
    // for out_valid. lat = rising edges after the accept edge.
    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        chk("in_ready_before_issue", in_ready, 1);
        op16 = op; a16 = a; b16 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; op16 = OP_MUL;
        lat = 0;
        busy_ready = 1'b0;
        while (!out_valid && lat < 100) begin
            busy_ready = busy_ready | in_ready;
            @(negedge clk);
            lat++;
        end
        $display("op=%0d a=%04h b=%04h -> lat=%0d d_out=%04h hi=%04h z=%b agb=%b bga=%b c=%b dz=%b",
                 op, a, b, lat, d_out, d_out_hi, z_flag, a_grt_b, b_grt_a, c_flag, dz_flag);
    endtask

    // MUL/DIV on the 8- or 32-bit DUT against a behavioural model
    task automatic run_w(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        logic [31:0] exp_lo, exp_hi, obs_lo, obs_hi;
        logic        obs_v, obs_z, obs_agb, obs_bga, obs_c, obs_dz;
        int          lat;
        prod = {32'b0, a} * {32'b0, b};
        if (op == OP_MUL) begin
            exp_lo = (w == 8) ? {24'b0, prod[7:0]}  : prod[31:0];
            exp_hi = (w == 8) ? {24'b0, prod[15:8]} : prod[63:32];
        end else begin
            exp_lo = a / b;
            exp_hi = a % b;
        end
        chk($sformatf("w%0d_in_ready", w), (w == 8) ? ir8 : ir32, 1);
        a_w = a; b_w = b; op_w = op;
        if (w == 8) iv8 = 1'b1; else iv32 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0; iv32 = 1'b0; a_w = $urandom; b_w = $urandom;
        lat = 0;
        obs_v = (w == 8) ? ov8 : ov32;
        while (!obs_v && lat < 200) begin
            @(negedge clk);
            lat++;
            obs_v = (w == 8) ? ov8 : ov32;
        end
        obs_lo  = (w == 8) ? {24'b0, lo8} : lo32;
        obs_hi  = (w == 8) ? {24'b0, hi8} : hi32;
        obs_z   = (w == 8) ? z8   : z32;
        obs_agb = (w == 8) ? agb8 : agb32;
        obs_bga = (w == 8) ? bga8 : bga32;
        obs_c   = (w == 8) ? c8   : c32;
        obs_dz  = (w == 8) ? dz8  : dz32;
        $display("w=%0d op=%0d a=%0h b=%0h -> lat=%0d lo=%0h hi=%0h (model lo=%0h hi=%0h)",
                 w, op, a, b, lat, obs_lo, obs_hi, exp_lo, exp_hi);
        chk($sformatf("w%0d_latency", w), lat, w);
        chk($sformatf("w%0d_lo", w), obs_lo, exp_lo);
        chk($sformatf("w%0d_hi", w), obs_hi, exp_hi);
        chk($sformatf("w%0d_z", w), obs_z, (exp_lo == 0));
        chk($sformatf("w%0d_agb", w), obs_agb, (a > b));
        chk($sformatf("w%0d_bga", w), obs_bga, (a < b));
        chk($sformatf("w%0d_c_dz", w), {obs_c, obs_dz}, 2'b00);
        @(negedge clk);
    endtask

    logic [2:0]  tp_op  [8];
    logic [15:0] tp_a   [8];
    logic [15:0] tp_b   [8];
    logic [15:0] tp_exp [8];
    logic        tp_z   [8];

    initial begin
        int lat;
        int seen;
        logic [31:0] ra, rb;

        tp_op  = '{OP_AND,  OP_OR,   OP_GT,   OP_LT,   OP_AND,  OP_OR,   OP_GT,   OP_LT};
        tp_a   = '{16'hF0F0, 16'hF0F0, 16'h8000, 16'h8000, 16'h1234, 16'h0000, 16'h0005, 16'h0004};
        tp_b   = '{16'h3C3C, 16'h0F0F, 16'h7FFF, 16'h7FFF, 16'h00FF, 16'h0000, 16'h0005, 16'h0005};
        tp_exp = '{16'h3030, 16'hFFFF, 16'h0001, 16'h0000, 16'h0034, 16'h0000, 16'h0000, 16'h0001};
        tp_z   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a16 = '0; b16 = '0; op16 = OP_ADD;
        iv8 = 1'b0; iv32 = 1'b0; or_w = 1'b1; a_w = '0; b_w = '0; op_w = OP_ADD;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_d_out_hi", d_out_hi, 0);
        chk("rst_flags", {z_flag, a_grt_b, b_grt_a, c_flag, dz_flag}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // ADD with carry out to zero
        out_ready = 1'b1;
        run16(OP_ADD, 16'hFFFF, 16'h0001, lat);
        chk("add_lat", lat, 0);
        chk("add_d_out", d_out, 16'h0000);
        chk("add_c", c_flag, 1);
        chk("add_z", z_flag, 1);
        chk("add_agb_bga", {a_grt_b, b_grt_a}, 2'b10);
        chk("add_hi", d_out_hi, 0);
        @(negedge clk);
        chk("add_back_idle", out_valid, 0);

        // MUL
        run16(OP_MUL, 16'h1234, 16'h5678, lat);
        chk("mul_lat", lat, 16);
        chk("mul_busy_in_ready", busy_ready, 0);
        chk("mul_lo", d_out, 16'h0060);
        chk("mul_hi", d_out_hi, 16'h0626);
        chk("mul_flags", {z_flag, a_grt_b, b_grt_a, c_flag, dz_flag}, 5'b00100);
        @(negedge clk);

        // DIV 100 / 7
        run16(OP_DIV, 16'd100, 16'd7, lat);
        chk("div_lat", lat, 16);
        chk("div_q", d_out, 16'd14);
        chk("div_r", d_out_hi, 16'd2);
        chk("div_flags", {z_flag, a_grt_b, b_grt_a, c_flag, dz_flag}, 5'b01000);
        @(negedge clk);

        // DIV by zero
        run16(OP_DIV, 16'h00AB, 16'h0000, lat);
        chk("dz_lat", lat, 0);
        chk("dz_q", d_out, 16'hFFFF);
        chk("dz_r", d_out_hi, 16'h00AB);
        chk("dz_flags", {z_flag, a_grt_b, b_grt_a, c_flag, dz_flag}, 5'b01001);
        @(negedge clk);

        // SUB under backpressure
        out_ready = 1'b0;
        run16(OP_SUB, 16'd5, 16'd9, lat);
        chk("sub_lat", lat, 0);
        chk("sub_d_out", d_out, 16'hFFFC);
        chk("sub_flags", {z_flag, a_grt_b, b_grt_a, c_flag, dz_flag}, 5'b00110);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_d_out", d_out, 16'hFFFC);
            chk("bp_c", c_flag, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", in_ready, 1);
        op16 = OP_ADD; a16 = 16'd3; b16 = 16'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        $display("same-edge ADD 3+4 -> out_valid=%b d_out=%04h", out_valid, d_out);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_d_out", d_out, 16'd7);
        chk("bp_next_flags", {z_flag, a_grt_b, b_grt_a, c_flag}, 4'b0010);

        // Eight back-to-back single-cycle ops
        for (int i = 0; i < 8; i++) begin
            op16 = tp_op[i]; a16 = tp_a[i]; b16 = tp_b[i]; in_valid = 1'b1;
            @(negedge clk);
            $display("tp[%0d] op=%0d a=%04h b=%04h -> valid=%b d_out=%04h z=%b",
                     i, tp_op[i], tp_a[i], tp_b[i], out_valid, d_out, z_flag);
            chk($sformatf("tp%0d_valid", i), out_valid, 1);
            chk($sformatf("tp%0d_d_out", i), d_out, tp_exp[i]);
            chk($sformatf("tp%0d_z", i), z_flag, tp_z[i]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("tp_drain_idle", out_valid, 0);

        // Reset mid-BUSY of a MUL
        op16 = OP_MUL; a16 = 16'h00FF; b16 = 16'h0101; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        $display("reset mid-BUSY -> out_valid=%b d_out=%04h bga=%b", out_valid, d_out, b_grt_a);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_d_out", d_out, 0);
        chk("abort_hi_flags", {d_out_hi, z_flag, a_grt_b, b_grt_a, c_flag, dz_flag}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_output", seen, 0);

        // Other widths: MUL/DIV against the model
        for (int k = 0; k < 6; k++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(1, 255);
            run_w(8, (k % 2 == 0) ? OP_MUL : OP_DIV, ra, rb);
        end
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k < 3) ? $urandom : $urandom_range(1, 65535);
            if (rb == 0) rb = 32'd1;
            run_w(32, (k % 2 == 0) ? OP_MUL : OP_DIV, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
